// File: rtl/dzcpu_oam_dma_pkg.sv
// Shared constants and state encoding for the dzcpu OAM DMA engine.
package dzcpu_oam_dma_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_RD   = 2'd1,
    DMA_WR   = 2'd2
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam int unsigned DMA_LEN      = 160;
  localparam logic [7:0]  DMA_LAST     = 8'(DMA_LEN - 1);

endpackage

// File: rtl/dzcpu_oam_dma_ctrl.sv
// OAM DMA sequencer: alternating read/write cycles, byte counter, source/destination address generation.
module dzcpu_oam_dma_ctrl
  import dzcpu_oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  src_page,
  input  logic        stall,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data,
  output logic        dma_we
);

  dma_state_t state, next_state;
  logic [7:0] count;
  logic [7:0] latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMA_IDLE;
      count <= '0;
      latch <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        count <= '0;
      end else if (!stall && state == DMA_WR) begin
        count <= count + 8'd1;
      end
      if (!start && !stall && state == DMA_RD) begin
        latch <= rd_data;
      end
    end
  end

  // A restart write overrides everything, including the final WR of a transfer.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = DMA_RD;
    end else if (!stall) begin
      unique case (state)
        DMA_IDLE: next_state = DMA_IDLE;
        DMA_RD:   next_state = DMA_WR;
        DMA_WR:   next_state = (count == DMA_LAST) ? DMA_IDLE : DMA_RD;
        default:  next_state = DMA_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    dma_addr = '0;
    dma_data = latch;
    dma_we   = 1'b0;
    unique case (state)
      DMA_RD: begin
        busy     = 1'b1;
        dma_addr = {src_page, count};
      end
      DMA_WR: begin
        busy     = 1'b1;
        dma_addr = OAM_BASE + {8'h00, count};
        dma_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dzcpu_oam_dma.sv
// OAM DMA block between the dzcpu memory port and the system bus; owns FF46 and arbitrates the bus.
module dzcpu_oam_dma
  import dzcpu_oam_dma_pkg::*;
(
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMemAddr,
  output logic [7:0]  oMemData,
  output logic        oMemWe,
  input  logic [7:0]  iMemData,
  output logic        oDmaBusy
);

  logic [7:0]  dma_reg;
  logic        cpu_is_reg;
  logic        cpu_hram;
  logic        start;
  logic        busy;
  logic        dma_owns;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_we;

  assign cpu_is_reg = (iCpuAddr == DMA_REG_ADDR);
  assign cpu_hram   = (iCpuAddr >= HRAM_BASE);
  assign start      = iCpuWe && cpu_is_reg;
  assign dma_owns   = busy && !cpu_hram;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      dma_reg <= '0;
    end else if (start) begin
      dma_reg <= iCpuData;
    end
  end

  // HRAM accesses win the bus; the engine only sees the stall while it is active.
  dzcpu_oam_dma_ctrl u_ctrl (
    .clk      (iClock),
    .rst_n    (iReset),
    .start    (start),
    .src_page (dma_reg),
    .stall    (cpu_hram),
    .rd_data  (iMemData),
    .busy     (busy),
    .dma_addr (dma_addr),
    .dma_data (dma_data),
    .dma_we   (dma_we)
  );

  always_comb begin
    if (dma_owns) begin
      oMemAddr = dma_addr;
      oMemData = dma_data;
      oMemWe   = dma_we;
    end else begin
      oMemAddr = iCpuAddr;
      oMemData = iCpuData;
      oMemWe   = iCpuWe && !cpu_is_reg;
    end
  end

  always_comb begin
    if (cpu_is_reg) begin
      oCpuData = dma_reg;
    end else if (dma_owns) begin
      oCpuData = 8'hFF;
    end else begin
      oCpuData = iMemData;
    end
  end

  assign oDmaBusy = busy;

endmodule

// File: tb/tb_dzcpu_oam_dma.sv
// Directed bench for dzcpu_oam_dma with a 64 KiB behavioural memory on the system bus.
module tb_dzcpu_oam_dma;

  logic        iClock;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe;
  logic [7:0]  oCpuData;
  logic [15:0] oMemAddr;
  logic [7:0]  oMemData;
  logic        oMemWe;
  logic [7:0]  iMemData;
  logic        oDmaBusy;

  logic [7:0]  mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  int          wr_cnt;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic [15:0] exp_maddr;
    logic        exp_mwe;
  } vec_t;

  vec_t vecs [6];

  dzcpu_oam_dma dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iCpuAddr (iCpuAddr),
    .iCpuData (iCpuData),
    .iCpuWe   (iCpuWe),
    .oCpuData (oCpuData),
    .oMemAddr (oMemAddr),
    .oMemData (oMemData),
    .oMemWe   (oMemWe),
    .iMemData (iMemData),
    .oDmaBusy (oDmaBusy)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  assign iMemData = mem[oMemAddr];

  always @(posedge iClock) begin
    if (oMemWe) begin
      mem[oMemAddr] <= oMemData;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic cpu(input logic [15:0] a, input logic [7:0] d, input logic we);
    iCpuAddr = a;
    iCpuData = d;
    iCpuWe   = we;
  endtask

  function automatic logic [7:0] pattern(input int kind, input int i);
    logic [7:0] b;
    b = 8'(i);
    case (kind)
      0:       return b ^ 8'h3C;
      1:       return ~b;
      default: return b + 8'h55;
    endcase
  endfunction

  task automatic preload(input logic [7:0] page, input int kind);
    for (int i = 0; i < 160; i++) begin
      pre_addr = {page, 8'(i)};
      pre_data = pattern(kind, i);
      pre_we   = 1'b1;
      step();
    end
    pre_we = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (oDmaBusy && n < 2000) begin
      step();
      n++;
    end
  endtask

  task automatic check_oam(input string name, input int kind);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (mem[16'hFE00 + 16'(i)] !== pattern(kind, i)) bad++;
    end
    check({name, "_first"}, 16'(mem[16'hFE00]), 16'(pattern(kind, 0)));
    check({name, "_last"}, 16'(mem[16'hFE9F]), 16'(pattern(kind, 159)));
    check({name, "_badbytes"}, 16'(bad), 16'd0);
  endtask

  task automatic start_dma(input logic [7:0] page);
    cpu(16'hFF46, page, 1'b1);
    #1;
    check("start_not_forwarded", 16'(oMemWe), 16'd0);
    step();
    cpu(16'h0000, 8'h00, 1'b0);
  endtask

  initial begin
    int n, tot, w0;
    checks = 0;
    errors = 0;
    wr_cnt = 0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    iReset = 1'b0;
    cpu(16'hFF46, 8'h00, 1'b0);

    // Reset state
    #12;
    check("rst_busy", 16'(oDmaBusy), 16'd0);
    check("rst_memwe", 16'(oMemWe), 16'd0);
    check("rst_ff46", 16'(oCpuData), 16'h00);
    step();
    iReset = 1'b1;
    step();

    // Idle pass-through vectors
    vecs[0] = '{16'hC000, 8'h5A, 1'b1, 1'b0, 8'h00, 16'hC000, 1'b1};
    vecs[1] = '{16'hC000, 8'h00, 1'b0, 1'b1, 8'h5A, 16'hC000, 1'b0};
    vecs[2] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'h00, 16'hFF46, 1'b0};
    vecs[3] = '{16'hFF90, 8'h11, 1'b1, 1'b0, 8'h00, 16'hFF90, 1'b1};
    vecs[4] = '{16'hFF90, 8'h00, 1'b0, 1'b1, 8'h11, 16'hFF90, 1'b0};
    vecs[5] = '{16'h1234, 8'hA7, 1'b0, 1'b0, 8'h00, 16'h1234, 1'b0};
    for (int v = 0; v < 6; v++) begin
      cpu(vecs[v].addr, vecs[v].data, vecs[v].we);
      #1;
      check($sformatf("vec%0d_maddr", v), oMemAddr, vecs[v].exp_maddr);
      check($sformatf("vec%0d_mwe", v), 16'(oMemWe), 16'(vecs[v].exp_mwe));
      check($sformatf("vec%0d_mdata", v), 16'(oMemData), 16'(vecs[v].data));
      check($sformatf("vec%0d_busy", v), 16'(oDmaBusy), 16'd0);
      if (vecs[v].chk_rd) check($sformatf("vec%0d_rd", v), 16'(oCpuData), 16'(vecs[v].exp_rd));
      step();
    end
    cpu(16'h0000, 8'h00, 1'b0);

    // Full transfer from C000
    preload(8'hC0, 0);
    w0 = wr_cnt;
    start_dma(8'hC0);
    wait_idle(n);
    check("full_busy_len", 16'(n), 16'd320);
    check("full_writes", 16'(wr_cnt - w0), 16'd160);
    check_oam("full_oam", 0);
    cpu(16'hFF46, 8'h00, 1'b0);
    #1;
    check("full_ff46", 16'(oCpuData), 16'h00C0);
    cpu(16'h0000, 8'h00, 1'b0);

    // Blocking of non-HRAM CPU accesses
    w0 = wr_cnt;
    start_dma(8'hC0);
    cpu(16'h8000, 8'h00, 1'b0);
    #1;
    check("blk_rd_ff", 16'(oCpuData), 16'h00FF);
    step();
    cpu(16'hFF46, 8'h00, 1'b0);
    #1;
    check("blk_ff46_rd", 16'(oCpuData), 16'h00C0);
    step();
    cpu(16'hC050, 8'h77, 1'b1);
    step();
    cpu(16'h0000, 8'h00, 1'b0);
    wait_idle(n);
    check("blk_busy_len", 16'(n + 3), 16'd320);
    check("blk_writes", 16'(wr_cnt - w0), 16'd160);
    check("blk_c050", 16'(mem[16'hC050]), 16'(8'h50 ^ 8'h3C));

    // HRAM priority stalls the engine
    preload(8'hE0, 1);
    w0 = wr_cnt;
    start_dma(8'hE0);
    tot = 0;
    for (int i = 0; i < 10; i++) begin step(); tot++; end
    for (int i = 0; i < 3; i++) begin
      cpu(16'hFF90, 8'hA5, 1'b1);
      #1;
      if (i == 0) begin
        check("hram_maddr", oMemAddr, 16'hFF90);
        check("hram_mwe", 16'(oMemWe), 16'd1);
      end
      step();
      tot++;
    end
    cpu(16'h0000, 8'h00, 1'b0);
    wait_idle(n);
    check("hram_busy_len", 16'(tot + n), 16'd323);
    check("hram_writes", 16'(wr_cnt - w0), 16'd163);
    check("hram_ff90", 16'(mem[16'hFF90]), 16'h00A5);
    check_oam("hram_oam", 1);

    // Restart mid-transfer
    preload(8'hD0, 2);
    start_dma(8'hC0);
    for (int i = 0; i < 50; i++) step();
    cpu(16'hFF46, 8'hD0, 1'b1);
    step();
    cpu(16'h0000, 8'h00, 1'b0);
    wait_idle(n);
    check("restart_busy_len", 16'(n), 16'd320);
    check_oam("restart_oam", 2);

    // Restart on the same edge as the final write
    start_dma(8'hC0);
    for (int i = 0; i < 319; i++) step();
    check("simul_pre_busy", 16'(oDmaBusy), 16'd1);
    cpu(16'hFF46, 8'hD0, 1'b1);
    step();
    cpu(16'h0000, 8'h00, 1'b0);
    #1;
    check("simul_busy", 16'(oDmaBusy), 16'd1);
    wait_idle(n);
    check("simul_busy_len", 16'(n), 16'd320);
    check_oam("simul_oam", 2);

    // Asynchronous reset mid-transfer
    start_dma(8'hC0);
    for (int i = 0; i < 100; i++) step();
    #2;
    iReset = 1'b0;
    #1;
    check("arst_busy", 16'(oDmaBusy), 16'd0);
    check("arst_memwe", 16'(oMemWe), 16'd0);
    step();
    iReset = 1'b1;
    step();
    cpu(16'hFF46, 8'h00, 1'b0);
    #1;
    check("arst_ff46", 16'(oCpuData), 16'h0000);
    cpu(16'hC000, 8'h00, 1'b0);
    #1;
    check("arst_pass_addr", oMemAddr, 16'hC000);
    check("arst_pass_rd", 16'(oCpuData), 16'h003C);
    check("arst_oam_new", 16'(mem[16'hFE00]), 16'h003C);
    check("arst_oam_old", 16'(mem[16'hFE60]), 16'h00B5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dzcpu_oam_dma.md
Name: dzcpu_oam_dma

Overview:
- Sits directly downstream of the dzcpu memory port, between the CPU bus (oMCUAddr/oMCUData/oMCUwe/iMCUData) and the system memory bus.
- Owns the OAM DMA register at FF46. A CPU write to FF46 starts a 160-byte copy from {value,8'h00} to FE00..FE9F.
- While the copy runs, the block arbitrates the single memory port: the DMA engine owns the bus, and the CPU sees only HRAM.
- When idle, the block is a transparent pass-through.

Parameters:
- DMA_REG_ADDR, 16'hFF46, address of the DMA source/start register.
- OAM_BASE, 16'hFE00, destination base address.
- DMA_LEN, 160, bytes per transfer.
- HRAM_BASE, 16'hFF80, lowest address the CPU may still reach during DMA.

Ports:
- iClock  in  1  system clock, rising edge.
- iReset  in  1  reset; active-low, asynchronous.
- iCpuAddr  in  16  CPU address (dzcpu oMCUAddr).
- iCpuData  in  8  CPU write data (dzcpu oMCUData).
- iCpuWe  in  1  CPU write enable (dzcpu oMCUwe).
- oCpuData  out  8  read data to CPU (dzcpu iMCUData).
- oMemAddr  out  16  memory bus address.
- oMemData  out  8  memory bus write data.
- oMemWe  out  1  memory bus write enable.
- iMemData  in  8  memory bus read data; combinational from oMemAddr.
- oDmaBusy  out  1  high while a transfer is in progress.

Behaviour:
- Reset (iReset low, asynchronous):
  - state=IDLE, count=0, rDmaReg=8'h00, rLatch=8'h00.
  - oDmaBusy=0, oMemWe=0.
  - oMemAddr/oMemData/oCpuData follow the IDLE pass-through rules.
- State machine: IDLE, RD, WR.
  - IDLE -> RD on a CPU write to DMA_REG_ADDR. The same edge loads rDmaReg=iCpuData and count=0.
  - RD:
    - oMemAddr={rDmaReg,count}, oMemWe=0.
    - At the clock edge, rLatch<=iMemData; go to WR.
  - WR:
    - oMemAddr=OAM_BASE+count, oMemData=rLatch, oMemWe=1.
    - At the clock edge, count<=count+1.
    - If count==DMA_LEN-1, go to IDLE; else go to RD.
  - A full transfer takes 320 cycles. oDmaBusy=1 in RD and WR.
- CPU writes to DMA_REG_ADDR:
  - Never forwarded to memory; oMemWe=0 for that access.
  - A CPU read of DMA_REG_ADDR returns rDmaReg, in any state.
- IDLE pass-through (all other addresses):
  - oMemAddr=iCpuAddr, oMemData=iCpuData, oMemWe=iCpuWe.
  - oCpuData=iMemData.
- Busy, CPU address < HRAM_BASE:
  - CPU writes are dropped.
  - CPU reads return 8'hFF.
  - The DMA engine owns the bus.
- Busy, CPU address >= HRAM_BASE (HRAM/IE, excluding DMA_REG_ADDR):
  - The CPU has priority and is passed through exactly as in IDLE.
  - The DMA engine stalls that cycle: state, count and rLatch hold.
  - HRAM accesses never stretch the transfer beyond 320 plus the number of stalled cycles.
- Restart: a CPU write to DMA_REG_ADDR while busy reloads rDmaReg, clears count and enters RD. The old transfer is abandoned; bytes already written stay.
- Source addressing:
  - The source high byte is used raw, so a source of FE00 reads OAM itself.
  - count is 8 bits, so {rDmaReg,count} never carries into the next page.
  - Destination is OAM_BASE+count; the sum is 16 bits with no wrap.
- Simultaneous events: a restart write on the same edge as the final WR wins. The block goes to RD with count=0 and oDmaBusy stays high.
- Reset mid-transfer: returns to IDLE immediately; the partial OAM contents are kept.

Decomposition:
- Shared package/include (aDefinitions.v): DMA state encodings (DMA_IDLE, DMA_RD, DMA_WR), DMA_REG_ADDR, OAM_BASE, HRAM_BASE, DMA_LEN.
- Natural sub-module: dzcpu_oam_dma_ctrl, containing the FSM, the count and address generation, and the stall input.
- Top level holds the bus muxes and the FF46 register.

Test Plan:
- Idle pass-through: CPU write C000<=5A, then read C000 -> oMemWe pulses 1 cycle at C000/5A; the read returns 5A; oDmaBusy=0.
- Full DMA: preload C000..C09F with i^8'h3C; CPU writes FF46<=C0 -> oDmaBusy high for exactly 320 cycles; FE00..FE9F = i^8'h3C; a FF46 read returns C0.
- Blocking: during DMA, CPU reads 8000 -> FF; CPU writes C050<=77 -> memory is unchanged and no extra oMemWe is seen.
- HRAM priority: during DMA, CPU writes FF90<=A5 for 3 cycles -> the write lands; the DMA holds count, so busy lasts 323 cycles and OAM data is still correct.
- Restart: write FF46<=C0, then 50 cycles later FF46<=D0 -> count resets; after 320 further cycles FE00..FE9F match D000..D09F.
- Async reset: assert iReset low at cycle 100 of a DMA -> oDmaBusy=0 and oMemWe=0 with no clock edge; after release the block is in pass-through and a FF46 read returns 00.
